// File: rtl/uart_rx.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose parity_err.
module uart_rx #(
    parameter int BIT_CYCLES = 10417,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rx_valid,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  frame_err,
    output logic                  overflow,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_err,
`endif
    input  logic                  err_clr
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] CNT_INC  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_INC = DEPTH_LOG2'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
`endif

    logic                  r_rx_meta, r_rx_s;
    logic [2:0]            r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic [7:0]            r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_frame_err, r_overflow;
    logic                  w_tick, w_stop_ok, w_frame_bad, w_good, w_full, w_pop, w_push, w_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick = (r_cnt == CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (!r_rx_s) w_next = START;
            START: if (r_cnt == CNT_HALF) w_next = r_rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (w_tick && r_bit == 3'd7) w_next = PARITY;
            PARITY: if (w_tick) w_next = STOP;
`else
            DATA:  if (w_tick && r_bit == 3'd7) w_next = STOP;
`endif
            STOP:  if (w_tick) w_next = r_rx_s ? IDLE : BREAK;
            BREAK: if (r_rx_s) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state != IDLE && r_state != BREAK)
                r_cnt <= w_tick ? '0 : r_cnt + CNT_ONE;
            if (r_state == START)
                r_bit <= '0;
            else if (r_state == DATA && w_tick)
                r_bit <= r_bit + 3'd1;
            if (r_state == DATA && w_tick)
                r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

    assign w_stop_ok   = (r_state == STOP) && w_tick && r_rx_s;
    assign w_frame_bad = (r_state == STOP) && w_tick && !r_rx_s;

`ifdef UART_RX_PARITY_EN
    logic r_par_bad, r_parity_err, w_par_bad;
    // Even parity: data ones plus the parity bit must be an even count.
    assign w_par_bad = (r_state == PARITY) && w_tick && ((^r_shift) ^ r_rx_s);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == PARITY && w_tick)
                r_par_bad <= w_par_bad;
            if (w_par_bad)
                r_parity_err <= 1'b1;
            else if (err_clr)
                r_parity_err <= 1'b0;
        end
    end
    assign parity_err = r_parity_err;
    assign w_good     = w_stop_ok && !r_par_bad;
`else
    assign w_good     = w_stop_ok;
`endif

    // A pop in the push cycle frees the slot, so a full FIFO can still accept.
    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = rd_en && rx_valid;
    assign w_push = w_good && (!w_full || w_pop);
    assign w_ovf  = w_good && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_INC;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_INC;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_INC;
                2'b01:   r_count <= r_count - CNT_INC;
                default: r_count <= r_count;
            endcase
            if (w_frame_bad)  r_frame_err <= 1'b1;
            else if (err_clr) r_frame_err <= 1'b0;
            if (w_ovf)        r_overflow  <= 1'b1;
            else if (err_clr) r_overflow  <= 1'b0;
        end
    end

    assign rd_data   = r_mem[r_rd_ptr];
    assign rx_valid  = (r_count != '0);
    assign rx_count  = r_count;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
endmodule
